// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU definitions: widths, control codes used by both the control
// decoder and the execute unit, FSM state type and overflow helpers.
package alu_exec_unit_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_CTRL_WIDTH = 4;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_MUL     = 4'b1000;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Signed overflow of a+b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between the issuing control FSM (master)
// and the execute unit (slave).
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH       = ALU_DATA_WIDTH,
  parameter int ALUCONTROL_WIDTH = ALU_CTRL_WIDTH
);

  logic                        in_valid;
  logic                        in_ready;
  logic [ALUCONTROL_WIDTH-1:0] alu_control;
  logic [DATA_WIDTH-1:0]       src_a;
  logic [DATA_WIDTH-1:0]       src_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       result;
  logic                        zero;
  logic                        overflow;
  logic                        err;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, err
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, err
  );

endinterface

// File: rtl/alu_exec_unit_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over
// DATA_WIDTH cycles, keeping only the low DATA_WIDTH bits of the product.
module alu_seq_mul
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] mcand_i,
  input  logic [DATA_WIDTH-1:0] mplier_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0]      count_q,  count_d;
  logic [DATA_WIDTH-1:0] acc_q,    acc_d;
  logic [DATA_WIDTH-1:0] mcand_q,  mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic                  busy_q,   busy_d;
  logic [DATA_WIDTH-1:0] acc_step_s;
  logic                  last_s;

  // Accumulator after this cycle's partial product; presented as the product
  // so the final iteration's sum is usable in the same cycle it is formed.
  always_comb begin
    acc_step_s = acc_q;
    if (mplier_q[0]) begin
      acc_step_s = acc_q + mcand_q;
    end else begin
      acc_step_s = acc_q;
    end
    last_s = busy_q && (count_q == LAST_CNT);
  end

  // Next-state for the iteration registers: load on start, step while busy.
  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    busy_d   = busy_q;
    if (start_i) begin
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step_s;
      mcand_d  = {mcand_q[DATA_WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DATA_WIDTH-1:1]};
      if (last_s) begin
        count_d = '0;
        busy_d  = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
        busy_d  = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state registers; reset abandons any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = last_s;
  assign product_o = acc_step_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, multi-cycle multiply,
// valid/ready handshake on both sides with registered results.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH       = ALU_DATA_WIDTH,
  parameter int ALUCONTROL_WIDTH = ALU_CTRL_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave alu_if
);

  localparam int MSB = DATA_WIDTH - 1;

  alu_state_e                  state_q,     state_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]       result_q,    result_d;
  logic                        zero_q,      zero_d;
  logic                        overflow_q,  overflow_d;
  logic                        err_q,       err_d;

  logic [ALUCONTROL_WIDTH-1:0] op_s;
  logic [DATA_WIDTH-1:0]       a_s, b_s, sum_s, diff_s;
  logic [DATA_WIDTH-1:0]       alu_res_s;
  logic                        alu_ovf_s, alu_err_s;
  logic                        in_ready_s, accept_s, mul_start_s;
  logic                        mul_busy_s, mul_done_s;
  logic [DATA_WIDTH-1:0]       mul_product_s;

  assign op_s   = alu_if.alu_control;
  assign a_s    = alu_if.src_a;
  assign b_s    = alu_if.src_b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // A new op is taken only when idle and the result slot is empty or draining now.
  assign in_ready_s = rst_n && (state_q == ST_IDLE) && (!out_valid_q || alu_if.out_ready);
  assign accept_s   = alu_if.in_valid && in_ready_s;

  alu_seq_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_seq_mul (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (mul_start_s),
    .mcand_i   (a_s),
    .mplier_i  (b_s),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // Single-cycle datapath; unknown codes yield zero with err flagged.
  always_comb begin
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    alu_err_s = 1'b0;
    case (op_s)
      ALU_AND: alu_res_s = a_s & b_s;
      ALU_OR:  alu_res_s = a_s | b_s;
      ALU_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_ovf(a_s[MSB], b_s[MSB], sum_s[MSB]);
      end
      ALU_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = sub_ovf(a_s[MSB], b_s[MSB], diff_s[MSB]);
      end
      ALU_SLT: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
      ALU_MUL: alu_res_s = '0;
      default: begin
        alu_res_s = '0;
        alu_err_s = 1'b1;
      end
    endcase
  end

  // FSM next state and result-register loading.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    err_d       = err_q;
    mul_start_s = 1'b0;

    if (out_valid_q && alu_if.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_s == ALU_MUL) begin
            state_d     = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            result_d    = alu_res_s;
            zero_d      = (alu_res_s == '0);
            overflow_d  = alu_ovf_s;
            err_d       = alu_err_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_product_s;
          zero_d      = (mul_product_s == '0);
          overflow_d  = 1'b0;
          err_d       = 1'b0;
        end else if (!mul_busy_s) begin
          // Multiplier lost its operation; recover to IDLE rather than hang.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  assign alu_if.in_ready  = in_ready_s;
  assign alu_if.out_valid = out_valid_q;
  assign alu_if.result    = result_q;
  assign alu_if.zero      = zero_q;
  assign alu_if.overflow  = overflow_q;
  assign alu_if.err       = err_q;

endmodule
